// File: rtl/cam_sched_pkg.sv
// rtl/cam_sched_pkg.sv - shared definitions for the CAM access scheduler
//
// Purpose : op encoding and the issue-slot record used by cam_access_scheduler.
// Contents: OP_LOOKUP / OP_UPDATE encodings, default field widths and
//           cam_issue_t (op, index, data, user) at the default widths.
package cam_sched_pkg;

  localparam logic OP_LOOKUP = 1'b0;
  localparam logic OP_UPDATE = 1'b1;

  localparam int DEF_KEY_SIZE   = 8;
  localparam int DEF_VALUE_SIZE = 32;
  localparam int DEF_USER_WIDTH = 4;

  typedef struct packed {
    logic                      op;
    logic [DEF_KEY_SIZE-1:0]   index;
    logic [DEF_VALUE_SIZE-1:0] data;
    logic [DEF_USER_WIDTH-1:0] user;
  } cam_issue_t;

endpackage

// File: rtl/cam_sched_credit.sv
// rtl/cam_sched_credit.sv - saturating up/down credit counter for in-flight lookups
//
// Purpose : counts lookups issued to the CAM and not yet answered.
// Ports   : clk, rst        clock, async active-high reset
//           inc_i          a lookup was accepted into the issue slot
//           dec_i          a lookup response completed its handshake
//           credits_avail  count < MAX_OUTSTANDING
module cam_sched_credit #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic credits_avail
);

  localparam logic [3:0] LIMIT = 4'(MAX_OUTSTANDING);

  logic [3:0] count_q, count_d;

  // Simultaneous inc and dec cancel. Decrement stops at zero so responses
  // that outlive a reset cannot drive the count negative.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      if (count_q < LIMIT) count_d = count_q + 4'd1;
    end else if (dec_i && !inc_i) begin
      if (count_q != 4'd0) count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 4'd0;
    else     count_q <= count_d;
  end

  assign credits_avail = (count_q < LIMIT);

endmodule

// File: rtl/cam_access_scheduler.sv
// rtl/cam_access_scheduler.sv - arbitrates lookup and update streams onto one CAM port
//
// Purpose : lookups win by default; an age counter forces a waiting update
//           through after UPDATE_MAX_WAIT bypasses. In-flight lookups are
//           limited by a credit counter; responses pass straight through.
// Ports   : s_lookup_*  lookup request stream (index, user, valid/ready)
//           s_update_*  update request stream (index, data, user, valid/ready)
//           m_cam_*     registered issue slot toward the CAM wrapper
//           cam_rsp_*   lookup responses from the CAM
//           m_rsp_*     responses forwarded downstream
//           stat_*      issue counters
// Macro   : CAM_SCHED_STATS_EN builds the stat counters; otherwise stat_* = 0.
module cam_access_scheduler
  import cam_sched_pkg::*;
#(
  parameter int KEY_SIZE        = 8,
  parameter int VALUE_SIZE      = 32,
  parameter int USER_WIDTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int UPDATE_MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_SIZE-1:0]   s_lookup_index,
  input  logic [USER_WIDTH-1:0] s_lookup_user,
  input  logic                  s_lookup_valid,
  output logic                  s_lookup_ready,
  input  logic [KEY_SIZE-1:0]   s_update_index,
  input  logic [VALUE_SIZE-1:0] s_update_data,
  input  logic [USER_WIDTH-1:0] s_update_user,
  input  logic                  s_update_valid,
  output logic                  s_update_ready,
  output logic                  m_cam_op,
  output logic [KEY_SIZE-1:0]   m_cam_index,
  output logic [VALUE_SIZE-1:0] m_cam_data,
  output logic [USER_WIDTH-1:0] m_cam_user,
  output logic                  m_cam_valid,
  input  logic                  m_cam_ready,
  input  logic [VALUE_SIZE-1:0] cam_rsp_data,
  input  logic [USER_WIDTH-1:0] cam_rsp_user,
  input  logic                  cam_rsp_valid,
  output logic                  cam_rsp_ready,
  output logic [VALUE_SIZE-1:0] m_rsp_data,
  output logic [USER_WIDTH-1:0] m_rsp_user,
  output logic                  m_rsp_valid,
  input  logic                  m_rsp_ready,
  output logic [31:0]           stat_lookups,
  output logic [31:0]           stat_updates,
  output logic [31:0]           stat_forced
);

  typedef struct packed {
    logic                  op;
    logic [KEY_SIZE-1:0]   index;
    logic [VALUE_SIZE-1:0] data;
    logic [USER_WIDTH-1:0] user;
  } slot_t;

  localparam logic [7:0] AGE_MAX = 8'(UPDATE_MAX_WAIT);

  slot_t      slot_q, slot_d;
  logic       valid_q, valid_d;
  logic [7:0] age_q, age_d;

  logic slot_free;
  logic force_w;
  logic lookup_ok;
  logic grant_upd;
  logic grant_lkp;
  logic credits_avail;
  logic rsp_hs;

  assign slot_free = !valid_q || m_cam_ready;
  assign force_w   = s_update_valid && (age_q == AGE_MAX);
  assign lookup_ok = s_lookup_valid && credits_avail;
  assign grant_upd = slot_free && s_update_valid && (force_w || !lookup_ok);
  assign grant_lkp = slot_free && lookup_ok && !grant_upd;

  assign s_lookup_ready = grant_lkp;
  assign s_update_ready = grant_upd;

  // Issue slot: load on grant, otherwise drain when the CAM takes it.
  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (grant_upd) begin
      slot_d.op    = OP_UPDATE;
      slot_d.index = s_update_index;
      slot_d.data  = s_update_data;
      slot_d.user  = s_update_user;
      valid_d      = 1'b1;
    end else if (grant_lkp) begin
      slot_d.op    = OP_LOOKUP;
      slot_d.index = s_lookup_index;
      slot_d.data  = '0;
      slot_d.user  = s_lookup_user;
      valid_d      = 1'b1;
    end else if (m_cam_ready) begin
      valid_d = 1'b0;
    end
  end

  // Age counts cycles a pending update goes unserved, saturating at the limit.
  always_comb begin
    age_d = age_q;
    if (!s_update_valid || grant_upd) age_d = 8'd0;
    else if (age_q < AGE_MAX)         age_d = age_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
      age_q   <= 8'd0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  assign m_cam_op    = slot_q.op;
  assign m_cam_index = slot_q.index;
  assign m_cam_data  = slot_q.data;
  assign m_cam_user  = slot_q.user;
  assign m_cam_valid = valid_q;

  assign m_rsp_data    = cam_rsp_data;
  assign m_rsp_user    = cam_rsp_user;
  assign m_rsp_valid   = cam_rsp_valid;
  assign cam_rsp_ready = m_rsp_ready;
  assign rsp_hs        = cam_rsp_valid && m_rsp_ready;

  cam_sched_credit #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk           (clk),
    .rst           (rst),
    .inc_i         (grant_lkp),
    .dec_i         (rsp_hs),
    .credits_avail (credits_avail)
  );

`ifdef CAM_SCHED_STATS_EN
  logic [31:0] stat_lookups_q, stat_updates_q, stat_forced_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups_q <= 32'd0;
      stat_updates_q <= 32'd0;
      stat_forced_q  <= 32'd0;
    end else begin
      if (grant_lkp)            stat_lookups_q <= stat_lookups_q + 32'd1;
      if (grant_upd)            stat_updates_q <= stat_updates_q + 32'd1;
      if (grant_upd && force_w) stat_forced_q  <= stat_forced_q + 32'd1;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_updates = stat_updates_q;
  assign stat_forced  = stat_forced_q;
`else
  assign stat_lookups = 32'd0;
  assign stat_updates = 32'd0;
  assign stat_forced  = 32'd0;
`endif

endmodule

// File: tb/tb_cam_access_scheduler.sv
// tb/tb_cam_access_scheduler.sv - self-checking bench for cam_access_scheduler
module tb_cam_access_scheduler;

  localparam int KS = 8;
  localparam int VS = 32;
  localparam int UW = 4;
  localparam int MO = 4;
  localparam int MW = 8;
`ifdef CAM_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [KS-1:0] s_lookup_index;
  logic [UW-1:0] s_lookup_user;
  logic          s_lookup_valid;
  logic          s_lookup_ready;
  logic [KS-1:0] s_update_index;
  logic [VS-1:0] s_update_data;
  logic [UW-1:0] s_update_user;
  logic          s_update_valid;
  logic          s_update_ready;
  logic          m_cam_op;
  logic [KS-1:0] m_cam_index;
  logic [VS-1:0] m_cam_data;
  logic [UW-1:0] m_cam_user;
  logic          m_cam_valid;
  logic          m_cam_ready;
  logic [VS-1:0] cam_rsp_data;
  logic [UW-1:0] cam_rsp_user;
  logic          cam_rsp_valid;
  logic          cam_rsp_ready;
  logic [VS-1:0] m_rsp_data;
  logic [UW-1:0] m_rsp_user;
  logic          m_rsp_valid;
  logic          m_rsp_ready;
  logic [31:0]   stat_lookups;
  logic [31:0]   stat_updates;
  logic [31:0]   stat_forced;

  cam_access_scheduler #(
    .KEY_SIZE(KS), .VALUE_SIZE(VS), .USER_WIDTH(UW),
    .MAX_OUTSTANDING(MO), .UPDATE_MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_lookup_index(s_lookup_index), .s_lookup_user(s_lookup_user),
    .s_lookup_valid(s_lookup_valid), .s_lookup_ready(s_lookup_ready),
    .s_update_index(s_update_index), .s_update_data(s_update_data),
    .s_update_user(s_update_user), .s_update_valid(s_update_valid),
    .s_update_ready(s_update_ready),
    .m_cam_op(m_cam_op), .m_cam_index(m_cam_index), .m_cam_data(m_cam_data),
    .m_cam_user(m_cam_user), .m_cam_valid(m_cam_valid), .m_cam_ready(m_cam_ready),
    .cam_rsp_data(cam_rsp_data), .cam_rsp_user(cam_rsp_user),
    .cam_rsp_valid(cam_rsp_valid), .cam_rsp_ready(cam_rsp_ready),
    .m_rsp_data(m_rsp_data), .m_rsp_user(m_rsp_user),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .stat_lookups(stat_lookups), .stat_updates(stat_updates), .stat_forced(stat_forced)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state (plain integers / records).
  int            md_credits, md_age, md_lk, md_up, md_fc;
  bit            md_valid, md_op;
  logic [KS-1:0] md_index;
  logic [VS-1:0] md_data;
  logic [UW-1:0] md_user;

  task automatic clear_inputs();
    s_lookup_index = '0; s_lookup_user = '0; s_lookup_valid = 1'b0;
    s_update_index = '0; s_update_data = '0; s_update_user = '0; s_update_valid = 1'b0;
    m_cam_ready = 1'b0;
    cam_rsp_data = '0; cam_rsp_user = '0; cam_rsp_valid = 1'b0;
    m_rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    md_credits = 0; md_age = 0; md_lk = 0; md_up = 0; md_fc = 0;
    md_valid = 1'b0; md_op = 1'b0; md_index = '0; md_data = '0; md_user = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (m_cam_valid !== 1'b0 || m_cam_op !== 1'b0 || m_cam_index !== '0 ||
        m_cam_data !== '0 || m_cam_user !== '0) begin
      failures++;
      $display("FAIL reset_slot valid=%0b op=%0b index=%h data=%h user=%h required all 0",
               m_cam_valid, m_cam_op, m_cam_index, m_cam_data, m_cam_user);
    end
    checks++;
    if (stat_lookups !== 32'd0 || stat_updates !== 32'd0 || stat_forced !== 32'd0) begin
      failures++;
      $display("FAIL reset_stats got=%0d/%0d/%0d required 0/0/0", stat_lookups, stat_updates, stat_forced);
    end
    checks++;
    if (s_lookup_ready !== 1'b0 || s_update_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%0b/%0b required 0/0", s_lookup_ready, s_update_ready);
    end
  endtask

  task automatic test_single_lookup();
    do_reset();
    s_lookup_index = 8'h12; s_lookup_user = 4'd3; s_lookup_valid = 1'b1; m_cam_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_lookup_ready !== 1'b1) begin
      failures++; $display("FAIL single_lookup_ready got=%0b required 1", s_lookup_ready);
    end
    @(posedge clk); #1;
    s_lookup_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_cam_valid !== 1'b1 || m_cam_op !== 1'b0 || m_cam_index !== 8'h12 ||
        m_cam_user !== 4'd3 || m_cam_data !== 32'd0) begin
      failures++;
      $display("FAIL single_lookup_issue valid=%0b op=%0b index=%h user=%0d data=%h required 1/0/12/3/0",
               m_cam_valid, m_cam_op, m_cam_index, m_cam_user, m_cam_data);
    end
  endtask

  task automatic test_credit_limit();
    do_reset();
    s_lookup_valid = 1'b1; s_update_valid = 1'b1; s_update_index = 8'hA5;
    s_update_data = 32'h0BAD_F00D; s_update_user = 4'd9; m_cam_ready = 1'b1; m_rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_lookup_index = 8'(i);
      @(negedge clk);
      checks++;
      if (s_lookup_ready !== (i < MO) || s_update_ready !== (i >= MO)) begin
        failures++;
        $display("FAIL credit_limit_grant cycle=%0d got=%0b/%0b required %0b/%0b",
                 i, s_lookup_ready, s_update_ready, i < MO, i >= MO);
      end
      if (i == MO + 1) begin
        checks++;
        if (m_cam_op !== 1'b1 || m_cam_index !== 8'hA5 || m_cam_data !== 32'h0BAD_F00D) begin
          failures++;
          $display("FAIL credit_limit_update_issue op=%0b index=%h data=%h required 1/a5/0badf00d",
                   m_cam_op, m_cam_index, m_cam_data);
        end
      end
      @(posedge clk); #1;
    end
    cam_rsp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (s_lookup_ready !== 1'b0) begin
      failures++; $display("FAIL credit_limit_hs_cycle got=%0b required 0", s_lookup_ready);
    end
    @(posedge clk); #1;
    cam_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_lookup_ready !== 1'b1) begin
      failures++; $display("FAIL credit_limit_after_rsp got=%0b required 1", s_lookup_ready);
    end
  endtask

  task automatic test_forced();
    do_reset();
    s_lookup_valid = 1'b1; s_update_valid = 1'b1; s_update_index = 8'h77; s_update_user = 4'd5;
    s_update_data = 32'h1234_5678; m_cam_ready = 1'b1; cam_rsp_valid = 1'b1; m_rsp_ready = 1'b1;
    for (int i = 0; i <= MW; i++) begin
      s_lookup_index = 8'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (s_update_ready !== (i == MW) || s_lookup_ready !== (i < MW)) begin
        failures++;
        $display("FAIL forced_grant cycle=%0d got=%0b/%0b required %0b/%0b",
                 i, s_lookup_ready, s_update_ready, i < MW, i == MW);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (m_cam_op !== 1'b1 || m_cam_index !== 8'h77) begin
      failures++; $display("FAIL forced_issue op=%0b index=%h required 1/77", m_cam_op, m_cam_index);
    end
    checks++;
    if (stat_forced !== (STATS ? 32'd1 : 32'd0) || stat_updates !== (STATS ? 32'd1 : 32'd0) ||
        stat_lookups !== (STATS ? 32'(MW) : 32'd0)) begin
      failures++;
      $display("FAIL forced_stats got=%0d/%0d/%0d", stat_lookups, stat_updates, stat_forced);
    end
    checks++;
    if (s_lookup_ready !== 1'b1 || s_update_ready !== 1'b0) begin
      failures++;
      $display("FAIL forced_age_cleared got=%0b/%0b required 1/0", s_lookup_ready, s_update_ready);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    s_lookup_index = 8'h21; s_lookup_user = 4'd1; s_lookup_valid = 1'b1; m_cam_ready = 1'b1;
    @(posedge clk); #1;
    s_lookup_index = 8'h22; s_lookup_user = 4'd2; m_cam_ready = 1'b0; s_update_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (m_cam_valid !== 1'b1 || m_cam_op !== 1'b0 || m_cam_index !== 8'h21 || m_cam_user !== 4'd1 ||
          s_lookup_ready !== 1'b0 || s_update_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold cycle=%0d valid=%0b index=%h user=%0d rdy=%0b/%0b",
                 i, m_cam_valid, m_cam_index, m_cam_user, s_lookup_ready, s_update_ready);
      end
      @(posedge clk); #1;
    end
    m_cam_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_lookup_ready !== 1'b1 || s_update_ready !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release got=%0b/%0b required 1/0", s_lookup_ready, s_update_ready);
    end
    @(posedge clk); #1;
    s_lookup_valid = 1'b0; s_update_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_cam_index !== 8'h22 || m_cam_user !== 4'd2) begin
      failures++;
      $display("FAIL backpressure_next index=%h user=%0d required 22/2", m_cam_index, m_cam_user);
    end
  endtask

  task automatic test_response();
    do_reset();
    s_lookup_valid = 1'b1; m_cam_ready = 1'b1;
    repeat (MO) begin
      @(posedge clk); #1;
    end
    cam_rsp_valid = 1'b1; cam_rsp_data = 32'hDEAD_BEEF; cam_rsp_user = 4'd2; m_rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (m_rsp_valid !== 1'b1 || m_rsp_data !== 32'hDEAD_BEEF || m_rsp_user !== 4'd2 ||
        cam_rsp_ready !== 1'b0 || s_lookup_ready !== 1'b0) begin
      failures++;
      $display("FAIL response_stall valid=%0b data=%h user=%0d crdy=%0b lrdy=%0b",
               m_rsp_valid, m_rsp_data, m_rsp_user, cam_rsp_ready, s_lookup_ready);
    end
    @(posedge clk); #1;
    m_rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cam_rsp_ready !== 1'b1 || s_lookup_ready !== 1'b0) begin
      failures++;
      $display("FAIL response_accept crdy=%0b lrdy=%0b required 1/0", cam_rsp_ready, s_lookup_ready);
    end
    @(posedge clk); #1;
    cam_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_lookup_ready !== 1'b1) begin
      failures++; $display("FAIL response_credit_return got=%0b required 1", s_lookup_ready);
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    s_lookup_valid = 1'b1; s_lookup_index = 8'h40; m_cam_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    s_lookup_valid = 1'b0; m_cam_ready = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (m_cam_valid !== 1'b0 || m_cam_index !== '0 || stat_lookups !== 32'd0) begin
      failures++;
      $display("FAIL midburst_reset valid=%0b index=%h lookups=%0d required 0/0/0",
               m_cam_valid, m_cam_index, stat_lookups);
    end
    @(posedge clk); #1 rst = 1'b0;
    cam_rsp_valid = 1'b1; cam_rsp_data = 32'h5A5A_0001; cam_rsp_user = 4'd7; m_rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_rsp_valid !== 1'b1 || m_rsp_data !== 32'h5A5A_0001 || m_rsp_user !== 4'd7) begin
      failures++;
      $display("FAIL midburst_late_rsp valid=%0b data=%h user=%0d", m_rsp_valid, m_rsp_data, m_rsp_user);
    end
    @(posedge clk); #1;
    cam_rsp_valid = 1'b0; s_lookup_valid = 1'b1; m_cam_ready = 1'b1;
    for (int i = 0; i <= MO; i++) begin
      @(negedge clk);
      checks++;
      if (s_lookup_ready !== (i < MO)) begin
        failures++;
        $display("FAIL midburst_credit_floor cycle=%0d got=%0b required %0b", i, s_lookup_ready, i < MO);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    bit free, g_up, g_lk, hs, forced;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      s_lookup_valid = ($urandom_range(0, 3) != 0);
      s_lookup_index = 8'($urandom);
      s_lookup_user  = 4'($urandom);
      s_update_valid = ($urandom_range(0, 2) == 0);
      s_update_index = 8'($urandom);
      s_update_data  = $urandom;
      s_update_user  = 4'($urandom);
      m_cam_ready    = ($urandom_range(0, 3) != 0);
      cam_rsp_valid  = ($urandom_range(0, 2) == 0);
      cam_rsp_data   = $urandom;
      cam_rsp_user   = 4'($urandom);
      m_rsp_ready    = ($urandom_range(0, 3) != 0);
      free   = !md_valid || m_cam_ready;
      forced = s_update_valid && (md_age == MW);
      g_up   = free && s_update_valid && (forced || !(s_lookup_valid && md_credits < MO));
      g_lk   = free && !g_up && s_lookup_valid && (md_credits < MO);
      hs     = cam_rsp_valid && m_rsp_ready;
      @(negedge clk);
      checks++;
      if (s_lookup_ready !== g_lk || s_update_ready !== g_up) begin
        failures++;
        $display("FAIL rnd_grant cycle=%0d got=%0b/%0b required %0b/%0b",
                 c, s_lookup_ready, s_update_ready, g_lk, g_up);
      end
      checks++;
      if (m_cam_valid !== md_valid || (md_valid && (m_cam_op !== md_op || m_cam_index !== md_index ||
          m_cam_data !== md_data || m_cam_user !== md_user))) begin
        failures++;
        $display("FAIL rnd_slot cycle=%0d got=%0b/%0b/%h/%h/%h required %0b/%0b/%h/%h/%h", c,
                 m_cam_valid, m_cam_op, m_cam_index, m_cam_data, m_cam_user,
                 md_valid, md_op, md_index, md_data, md_user);
      end
      checks++;
      if (m_rsp_valid !== cam_rsp_valid || m_rsp_data !== cam_rsp_data ||
          m_rsp_user !== cam_rsp_user || cam_rsp_ready !== m_rsp_ready) begin
        failures++;
        $display("FAIL rnd_rsp cycle=%0d got=%0b/%h/%0d/%0b", c, m_rsp_valid, m_rsp_data, m_rsp_user, cam_rsp_ready);
      end
      checks++;
      if (stat_lookups !== (STATS ? 32'(md_lk) : 32'd0) || stat_updates !== (STATS ? 32'(md_up) : 32'd0) ||
          stat_forced !== (STATS ? 32'(md_fc) : 32'd0)) begin
        failures++;
        $display("FAIL rnd_stats cycle=%0d got=%0d/%0d/%0d required %0d/%0d/%0d", c,
                 stat_lookups, stat_updates, stat_forced, md_lk, md_up, md_fc);
      end
      @(posedge clk);
      if (g_lk && !hs)                         md_credits++;
      else if (hs && !g_lk && md_credits > 0)  md_credits--;
      md_age = (!s_update_valid || g_up) ? 0 : ((md_age < MW) ? md_age + 1 : MW);
      if (g_up) begin
        md_valid = 1'b1; md_op = 1'b1; md_index = s_update_index;
        md_data = s_update_data; md_user = s_update_user; md_up++;
        if (forced) md_fc++;
      end else if (g_lk) begin
        md_valid = 1'b1; md_op = 1'b0; md_index = s_lookup_index;
        md_data = '0; md_user = s_lookup_user; md_lk++;
      end else if (m_cam_ready) begin
        md_valid = 1'b0;
      end
      #1;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_lookup();
    test_credit_limit();
    test_forced();
    test_backpressure();
    test_response();
    test_reset_midburst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cam_access_scheduler.md
Name: cam_access_scheduler

Overview:
- Shares the single-issue CAM wrapper between one lookup request stream and one update request stream, both already merged per class by the upstream port muxes.
- Lookups have priority. An age counter forces an update grant so updates cannot starve.
- Limits in-flight lookups with a credit counter and passes lookup responses back through unchanged.
- Sits between the per-class port muxes and the CAM wrapper.

Parameters:
- KEY_SIZE, 8, key/index width
- VALUE_SIZE, 32, value width
- USER_WIDTH, 4, requester tag width carried with each request and response
- MAX_OUTSTANDING, 4, maximum lookups issued but not yet answered (1..15)
- UPDATE_MAX_WAIT, 8, cycles a pending update may be bypassed before it is forced (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_lookup_index  in  KEY_SIZE  lookup key
- s_lookup_user  in  USER_WIDTH  lookup tag
- s_lookup_valid  in  1  lookup request valid
- s_lookup_ready  out  1  lookup request accepted
- s_update_index  in  KEY_SIZE  update key
- s_update_data  in  VALUE_SIZE  update value
- s_update_user  in  USER_WIDTH  update tag
- s_update_valid  in  1  update request valid
- s_update_ready  out  1  update request accepted
- m_cam_op  out  1  0 = lookup, 1 = update
- m_cam_index  out  KEY_SIZE  issued key
- m_cam_data  out  VALUE_SIZE  issued value; 0 for lookups
- m_cam_user  out  USER_WIDTH  issued tag
- m_cam_valid  out  1  issue valid
- m_cam_ready  in  1  CAM accepts issue
- cam_rsp_data  in  VALUE_SIZE  lookup result from CAM
- cam_rsp_user  in  USER_WIDTH  result tag
- cam_rsp_valid  in  1  result valid
- cam_rsp_ready  out  1  result accepted
- m_rsp_data  out  VALUE_SIZE  forwarded result
- m_rsp_user  out  USER_WIDTH  forwarded tag
- m_rsp_valid  out  1  forwarded valid
- m_rsp_ready  in  1  downstream accepts result
- stat_lookups  out  32  lookups issued
- stat_updates  out  32  updates issued
- stat_forced  out  32  forced update grants

Behaviour:
- Reset (async, immediate): m_cam_valid=0, m_cam_op=0, m_cam_index/data/user=0, credit count=0, age=0, stats=0.
  - An issue in flight at reset is dropped.
  - Responses that arrive after reset are still passed through, but the credit counter is not decremented below 0.
- Issue register: a single output slot. It can load in cycle t when slot_free = !m_cam_valid || m_cam_ready.
  - Loaded content appears on m_cam_* at t+1.
  - m_cam_* stays stable while m_cam_valid && !m_cam_ready.
- Grant, evaluated combinationally only when slot_free:
  - force = s_update_valid && (age == UPDATE_MAX_WAIT)
  - lookup_ok = s_lookup_valid && (credits < MAX_OUTSTANDING)
  - Grant the update if force, or if s_update_valid && !lookup_ok. Otherwise grant the lookup if lookup_ok.
  - s_lookup_ready / s_update_ready are high only for the granted source. They never assert together.
- Age counter:
  - Cleared when an update is accepted or when s_update_valid=0.
  - Incremented, saturating at UPDATE_MAX_WAIT, each cycle s_update_valid=1 and the update is not accepted.
- Credit counter, 4 bits:
  - +1 on lookup acceptance into the slot; -1 on cam_rsp handshake.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Response path: pure combinational pass-through.
  - m_rsp_* = cam_rsp_*; cam_rsp_ready = m_rsp_ready.
  - No reordering; tags are preserved.
- Updates consume no credit and produce no response.
- Throughput: one issue per cycle when m_cam_ready is held high.

Optional Feature:
- CAM_SCHED_STATS_EN defined:
  - stat_lookups, stat_updates and stat_forced count issue-slot loads of each kind.
  - stat_forced counts update grants taken with force=1.
  - All three wrap at 2^32.
- Undefined: all three stat ports are driven to constant 0 and no counter flops are built.

Decomposition:
- Package cam_sched_pkg:
  - op encoding constants OP_LOOKUP=1'b0, OP_UPDATE=1'b1
  - issue-slot struct typedef {op, index, data, user}
- One sub-module, cam_sched_credit: the saturating up/down credit counter. Outputs credits_avail = (count < MAX_OUTSTANDING).

Test Plan:
- Lookup key 0x12, user 3, m_cam_ready=1 -> next cycle m_cam_valid=1, m_cam_op=0, m_cam_index=0x12, m_cam_user=3, m_cam_data=0; credits=1.
- Lookups and update both valid continuously, no responses, MAX_OUTSTANDING=4 -> 4 lookups issue, then the update issues on the 5th slot, then s_lookup_ready stays 0 until a response handshake.
- Lookups always valid, responses returned every cycle, update valid, UPDATE_MAX_WAIT=8 -> update issues after exactly 8 bypass cycles with stat_forced=1 (macro defined); age then resets to 0.
- m_cam_ready=0 for 5 cycles with an issue pending -> m_cam_* unchanged for all 5 cycles and both s_*_ready=0; first cycle with m_cam_ready=1 the next request loads.
- cam_rsp_valid with data 0xDEADBEEF, user 2, m_rsp_ready=0 then 1 -> m_rsp mirrors the response, cam_rsp_ready follows m_rsp_ready, credit decrements only on the ready=1 cycle.
- rst asserted mid-burst with 3 credits outstanding and m_cam_valid=1 -> immediate m_cam_valid=0, credits=0, stats=0. A late response still passes through and credits stay 0.
